write_results: RTL and testbench

AXI4 write master that drains an AXI4-Stream of kernel results into device memory; it is the write-side counterpart of the genome read path. On `ctrl_start` it latches a base address and byte count and splits the transfer into 4 KiB-max bursts. It then issues AW requests within an outstanding-transaction limit and forwards stream beats onto W with correct `wlast`. It pulses `ctrl_done` after the final B response. It sits between the kernel compute stage and the memory-side AXI interconnect.

---
 rtl/write_results_if.sv | 57 +++++
 rtl/write_results.sv | 164 ++++++++++++++++
 tb/tb_write_results.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_results_if.sv
// Control, AXI4 write-master and AXI4-Stream bundle for write_results.
// master = the write engine; slave = the kernel/interconnect side driving it.
interface write_results_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int XFER_W = 32
);
    logic                  ctrl_start;
    logic                  ctrl_done;
    logic [ADDR_W-1:0]     ctrl_addr_offset;
    logic [XFER_W-1:0]     ctrl_xfer_size_in_bytes;

    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [ADDR_W-1:0]     m_axi_awaddr;
    logic [7:0]            m_axi_awlen;

    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [DATA_W-1:0]     m_axi_wdata;
    logic [DATA_W/8-1:0]   m_axi_wstrb;
    logic                  m_axi_wlast;

    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_W-1:0]     s_axis_tdata;
    logic                  s_axis_tlast;

    modport master (
        input  ctrl_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes,
        output ctrl_done,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        input  m_axi_wready,
        input  m_axi_bvalid,
        output m_axi_bready,
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output s_axis_tready
    );

    modport slave (
        output ctrl_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes,
        input  ctrl_done,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        output m_axi_wready,
        output m_axi_bvalid,
        input  m_axi_bready,
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  s_axis_tready
    );
endinterface

// File: rtl/write_results.sv
// AXI4 write master draining a result stream into memory in <=4 KiB bursts.
// First AW one cycle after start, W is a zero-latency pass-through; AW stalls at the outstanding limit, W stalls until its AW is accepted.
module write_results #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic            aclk,
    input  logic            areset_n,
    write_results_if.master bus
);
    localparam int LP_DW_BYTES    = C_M_AXI_DATA_WIDTH / 8;
    localparam int LP_LOG_DW      = $clog2(LP_DW_BYTES);
    localparam int LP_BURST_LEN   = ((4096 / LP_DW_BYTES) < 256) ? (4096 / LP_DW_BYTES) : 256;
    localparam int LP_LOG_BL      = $clog2(LP_BURST_LEN);
    localparam int LP_BURST_BYTES = LP_BURST_LEN * LP_DW_BYTES;
    localparam int LP_CNT_W       = C_XFER_SIZE_WIDTH - LP_LOG_DW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                        state;
    logic [LP_CNT_W-1:0]           bursts;
    logic [LP_CNT_W-1:0]           aw_acc;
    logic [LP_CNT_W-1:0]           b_cnt;
    logic [LP_CNT_W-1:0]           w_cnt;
    logic [LP_LOG_BL:0]            last_len;
    logic [LP_LOG_BL-1:0]          beat_cnt;
    logic                          awvalid;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                    awlen;
    logic                          bready;
    logic                          ctrl_done;

    logic [LP_CNT_W-1:0]           beats_start;
    logic [LP_CNT_W-1:0]           bursts_start;
    logic [LP_LOG_BL:0]            last_len_start;
    logic [7:0]                    awlen_start;
    logic                          size_zero;

    logic                          aw_hs;
    logic                          b_hs;
    logic                          w_hs;
    logic                          burst_open;
    logic                          wlast;
    logic [LP_CNT_W-1:0]           bursts_m1;
    logic [LP_LOG_BL:0]            cur_len;
    logic [LP_CNT_W-1:0]           aw_acc_n;
    logic [LP_CNT_W-1:0]           b_cnt_n;
    logic [LP_CNT_W-1:0]           outstanding_n;
    logic                          aw_more;
    logic [7:0]                    awlen_n;

    // Transfer geometry, evaluated on the start cycle only.
    assign size_zero      = (bus.ctrl_xfer_size_in_bytes == '0);
    assign beats_start    = LP_CNT_W'(bus.ctrl_xfer_size_in_bytes >> LP_LOG_DW)
                          + LP_CNT_W'(|bus.ctrl_xfer_size_in_bytes[LP_LOG_DW-1:0]);
    assign bursts_start   = (beats_start >> LP_LOG_BL)
                          + LP_CNT_W'(|beats_start[LP_LOG_BL-1:0]);
    assign last_len_start = (beats_start[LP_LOG_BL-1:0] == '0)
                          ? (LP_LOG_BL+1)'(LP_BURST_LEN)
                          : {1'b0, beats_start[LP_LOG_BL-1:0]};
    assign awlen_start    = (bursts_start == LP_CNT_W'(1))
                          ? 8'(last_len_start - (LP_LOG_BL+1)'(1))
                          : 8'(LP_BURST_LEN - 1);

    assign aw_hs      = awvalid & bus.m_axi_awready;
    assign b_hs       = bus.m_axi_bvalid & bready & (state == S_RUN);
    assign burst_open = (state == S_RUN) && (w_cnt < aw_acc);
    assign w_hs       = bus.s_axis_tvalid & bus.m_axi_wready & burst_open;

    assign bursts_m1  = bursts - LP_CNT_W'(1);
    assign cur_len    = (w_cnt == bursts_m1) ? last_len : (LP_LOG_BL+1)'(LP_BURST_LEN);
    assign wlast      = burst_open && ({1'b0, beat_cnt} == (cur_len - (LP_LOG_BL+1)'(1)));

    // Next-cycle counter view: a B landing with an AW keeps the outstanding count level.
    assign aw_acc_n      = aw_acc + LP_CNT_W'(aw_hs);
    assign b_cnt_n       = b_cnt + LP_CNT_W'(b_hs);
    assign outstanding_n = aw_acc_n - b_cnt_n;
    assign aw_more       = (aw_acc_n < bursts) && (outstanding_n < LP_CNT_W'(C_MAX_OUTSTANDING));
    assign awlen_n       = (aw_acc_n == bursts_m1)
                         ? 8'(last_len - (LP_LOG_BL+1)'(1))
                         : 8'(LP_BURST_LEN - 1);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= S_IDLE;
            bursts    <= '0;
            last_len  <= '0;
            aw_acc    <= '0;
            b_cnt     <= '0;
            w_cnt     <= '0;
            beat_cnt  <= '0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            awlen     <= '0;
            bready    <= 1'b0;
            ctrl_done <= 1'b0;
        end else begin
            bready    <= 1'b1;
            ctrl_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.ctrl_start) begin
                        bursts   <= bursts_start;
                        last_len <= last_len_start;
                        aw_acc   <= '0;
                        b_cnt    <= '0;
                        w_cnt    <= '0;
                        beat_cnt <= '0;
                        awaddr   <= bus.ctrl_addr_offset;
                        awlen    <= awlen_start;
                        if (size_zero) begin
                            state     <= S_DONE;
                            ctrl_done <= 1'b1;
                        end else begin
                            state   <= S_RUN;
                            awvalid <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    aw_acc  <= aw_acc_n;
                    b_cnt   <= b_cnt_n;
                    awvalid <= aw_more;
                    if (aw_hs) begin
                        awaddr <= awaddr + C_M_AXI_ADDR_WIDTH'(LP_BURST_BYTES);
                        awlen  <= awlen_n;
                    end
                    if (w_hs) begin
                        if (wlast) begin
                            beat_cnt <= '0;
                            w_cnt    <= w_cnt + LP_CNT_W'(1);
                        end else begin
                            beat_cnt <= beat_cnt + LP_LOG_BL'(1);
                        end
                    end
                    if (b_cnt_n == bursts) begin
                        state     <= S_DONE;
                        ctrl_done <= 1'b1;
                        awvalid   <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ctrl_done     = ctrl_done;
    assign bus.m_axi_awvalid = awvalid;
    assign bus.m_axi_awaddr  = awaddr;
    assign bus.m_axi_awlen   = awlen;
    assign bus.m_axi_bready  = bready;
    assign bus.m_axi_wvalid  = bus.s_axis_tvalid & burst_open;
    assign bus.s_axis_tready = bus.m_axi_wready & burst_open;
    assign bus.m_axi_wdata   = bus.s_axis_tdata;
    assign bus.m_axi_wstrb   = '1;
    assign bus.m_axi_wlast   = wlast;
endmodule

// File: tb/tb_write_results.sv
// Directed bench for write_results: memory-side responder, stream source and handshake logger.
module tb_write_results;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int XW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    write_results_if #(.ADDR_W(AW), .DATA_W(DW), .XFER_W(XW)) bus ();

    write_results #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_XFER_SIZE_WIDTH (XW),
        .C_MAX_OUTSTANDING (16)
    ) dut (
        .aclk    (clk),
        .areset_n(rst_n),
        .bus     (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rand_t = 0, rand_w = 0, rand_aw = 0, b_hold = 0, src_en = 0;

    int aw_n = 0, w_n = 0, t_n = 0, wl_n = 0, b_n = 0, done_n = 0;
    int av_n = 0, wv_n = 0, stab_err = 0, early_err = 0;
    int b_owed = 0, aw_r = 0, wl_r = 0;
    int last_b_cyc = 0, last_done_cyc = 0;
    logic [AW-1:0] aw_addr_log [4096];
    logic [7:0]    aw_len_log  [4096];
    int            aw_cyc_log  [4096];
    logic [DW-1:0] w_data_log  [8192];
    bit            w_last_log  [8192];
    logic          prev_pend = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [7:0]    prev_len  = '0;

    function automatic logic [DW-1:0] pat(input int k);
        logic [31:0] w;
        w = 32'(k) ^ 32'hC0DE0000;
        return {16{w}};
    endfunction

    // Logs everything that will handshake on the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            b_owed    = 0;
            aw_r      = 0;
            wl_r      = 0;
            prev_pend = 1'b0;
        end else begin
            if (bus.m_axi_awvalid) av_n++;
            if (bus.m_axi_wvalid)  wv_n++;
            if (prev_pend && (!bus.m_axi_awvalid || bus.m_axi_awaddr != prev_addr ||
                              bus.m_axi_awlen != prev_len)) stab_err++;
            prev_pend = bus.m_axi_awvalid && !bus.m_axi_awready;
            prev_addr = bus.m_axi_awaddr;
            prev_len  = bus.m_axi_awlen;
            if (bus.m_axi_wvalid && wl_r >= aw_r) early_err++;
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                aw_addr_log[aw_n % 4096] = bus.m_axi_awaddr;
                aw_len_log[aw_n % 4096]  = bus.m_axi_awlen;
                aw_cyc_log[aw_n % 4096]  = cyc;
                aw_n++;
                aw_r++;
            end
            if (bus.s_axis_tvalid && bus.s_axis_tready) t_n++;
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                w_data_log[w_n % 8192] = bus.m_axi_wdata;
                w_last_log[w_n % 8192] = bus.m_axi_wlast;
                w_n++;
                if (bus.m_axi_wlast) begin
                    wl_n++;
                    wl_r++;
                    b_owed++;
                end
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) begin
                b_n++;
                b_owed--;
                last_b_cyc = cyc;
            end
            if (bus.ctrl_done) begin
                done_n++;
                last_done_cyc = cyc;
            end
        end
    end

    // Memory responder and stream source, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        bus.m_axi_awready = rand_aw ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.m_axi_wready  = rand_w  ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.m_axi_bvalid  = (b_owed > 0) && !b_hold;
        bus.s_axis_tvalid = src_en && (rand_t ? ($urandom_range(0, 3) != 0) : 1'b1);
        bus.s_axis_tdata  = pat(t_n);
        bus.s_axis_tlast  = 1'b0;
    end

    task automatic do_start(input logic [AW-1:0] addr, input logic [XW-1:0] size, output int t);
        @(posedge clk); #1;
        bus.ctrl_addr_offset        = addr;
        bus.ctrl_xfer_size_in_bytes = size;
        bus.ctrl_start              = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        bus.ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.ctrl_done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.ctrl_start              = 1'b0;
        bus.ctrl_addr_offset        = '0;
        bus.ctrl_xfer_size_in_bytes = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast, bus.s_axis_tready,
             bus.ctrl_done, bus.m_axi_bready} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 000000", {bus.m_axi_awvalid, bus.m_axi_wvalid,
                     bus.m_axi_wlast, bus.s_axis_tready, bus.ctrl_done, bus.m_axi_bready});
        end
        vectors++;
        if (bus.m_axi_awaddr !== '0 || bus.m_axi_awlen !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_aw: got addr %h len %0d expected 0/0", bus.m_axi_awaddr, bus.m_axi_awlen);
        end
        #2 rst_n = 1'b1;
        src_en = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.m_axi_bready !== 1'b1 || bus.m_axi_wvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got bready %b wvalid %b expected 1/0", bus.m_axi_bready, bus.m_axi_wvalid);
        end
    endtask

    // Shared checks for a completed transfer of given geometry starting at addr.
    task automatic test_transfer(input string name, input logic [AW-1:0] addr, input logic [XW-1:0] size,
                                 input int nbeats, input int check_latency);
        int a0, w0, d0, b0, t, nb, errs_d, errs_l, errs_a;
        bit ok;
        a0 = aw_n; w0 = w_n; d0 = done_n; b0 = b_n;
        nb = (nbeats + 63) / 64;
        do_start(addr, size, t);
        wait_done(8000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_done: ctrl_done not seen within budget", name);
        end
        vectors++;
        if (aw_n - a0 != nb || b_n - b0 != nb) begin
            miscompares++;
            $display("FAIL %s_counts: got aw %0d b %0d expected %0d", name, aw_n - a0, b_n - b0, nb);
        end
        errs_a = 0;
        for (int k = 0; k < nb; k++) begin
            if (aw_addr_log[(a0 + k) % 4096] !== addr + AW'(k * 4096)) errs_a++;
            if (aw_len_log[(a0 + k) % 4096] !== ((k == nb - 1) ? 8'(nbeats - 64 * (nb - 1) - 1) : 8'd63)) errs_a++;
        end
        vectors++;
        if (errs_a != 0) begin
            miscompares++;
            $display("FAIL %s_aw: %0d bad addr/len fields, expected 0", name, errs_a);
        end
        vectors++;
        if (w_n - w0 != nbeats) begin
            miscompares++;
            $display("FAIL %s_beats: got %0d expected %0d", name, w_n - w0, nbeats);
        end
        errs_d = 0;
        errs_l = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (w_data_log[(w0 + i) % 8192] !== pat(w0 + i)) errs_d++;
            if (w_last_log[(w0 + i) % 8192] !== ((i % 64 == 63) || (i == nbeats - 1))) errs_l++;
        end
        vectors++;
        if (errs_d != 0) begin
            miscompares++;
            $display("FAIL %s_data: %0d beats out of order, expected 0", name, errs_d);
        end
        vectors++;
        if (errs_l != 0) begin
            miscompares++;
            $display("FAIL %s_wlast: %0d misplaced wlast, expected 0", name, errs_l);
        end
        vectors++;
        if (done_n - d0 != 1 || last_done_cyc != last_b_cyc + 1) begin
            miscompares++;
            $display("FAIL %s_done_pulse: got %0d pulses at cycle %0d expected 1 at %0d",
                     name, done_n - d0, last_done_cyc, last_b_cyc + 1);
        end
        if (check_latency != 0) begin
            vectors++;
            if (aw_cyc_log[a0 % 4096] != t + 1) begin
                miscompares++;
                $display("FAIL %s_aw_latency: got cycle %0d expected %0d", name, aw_cyc_log[a0 % 4096], t + 1);
            end
        end
    endtask

    task automatic test_single_burst();
        test_transfer("single", 64'h1000, 32'd4096, 64, 1);
    endtask

    task automatic test_three_bursts();
        test_transfer("three", 64'h0, 32'd8256, 129, 1);
    endtask

    task automatic test_zero_size();
        int v0, w0, t;
        bit ok;
        v0 = av_n; w0 = wv_n;
        do_start(64'h3000, 32'd0, t);
        wait_done(10, ok);
        vectors++;
        if (!ok || last_done_cyc != t + 1) begin
            miscompares++;
            $display("FAIL zero_done: got seen %0d cycle %0d expected 1 at %0d", ok, last_done_cyc, t + 1);
        end
        vectors++;
        if (av_n != v0 || wv_n != w0) begin
            miscompares++;
            $display("FAIL zero_traffic: got awvalid %0d wvalid %0d cycles expected 0/0", av_n - v0, wv_n - w0);
        end
    endtask

    task automatic test_outstanding();
        int a0, w0, wl0, t;
        bit ok;
        a0 = aw_n; w0 = w_n; wl0 = wl_n;
        b_hold = 1'b1;
        do_start(64'h0, 32'd163840, t);
        repeat (1500) @(negedge clk);
        vectors++;
        if (aw_n - a0 != 16) begin
            miscompares++;
            $display("FAIL outst_limit: got %0d AW handshakes expected 16", aw_n - a0);
        end
        vectors++;
        if (bus.m_axi_awvalid !== 1'b0 || w_n - w0 != 1024) begin
            miscompares++;
            $display("FAIL outst_blocked: got awvalid %b beats %0d expected 0/1024", bus.m_axi_awvalid, w_n - w0);
        end
        b_hold = 1'b0;
        wait_done(5000, ok);
        vectors++;
        if (!ok || aw_n - a0 != 40 || wl_n - wl0 != 40 || w_n - w0 != 2560) begin
            miscompares++;
            $display("FAIL outst_release: got done %0d aw %0d wlast %0d beats %0d expected 1/40/40/2560",
                     ok, aw_n - a0, wl_n - wl0, w_n - w0);
        end
        vectors++;
        if (aw_addr_log[(a0 + 39) % 4096] !== 64'h27000 || aw_len_log[(a0 + 39) % 4096] !== 8'd63) begin
            miscompares++;
            $display("FAIL outst_last_aw: got %h/%0d expected 27000/63",
                     aw_addr_log[(a0 + 39) % 4096], aw_len_log[(a0 + 39) % 4096]);
        end
    endtask

    task automatic test_random_flow();
        int s0, e0;
        s0 = stab_err; e0 = early_err;
        rand_t = 1'b1; rand_w = 1'b1; rand_aw = 1'b1;
        test_transfer("random", 64'h10000, 32'd12800, 200, 0);
        rand_t = 1'b0; rand_w = 1'b0; rand_aw = 1'b0;
        vectors++;
        if (stab_err != s0 || early_err != e0) begin
            miscompares++;
            $display("FAIL random_protocol: got %0d AW-unstable %0d early-W cycles expected 0/0",
                     stab_err - s0, early_err - e0);
        end
        vectors++;
        if (t_n != w_n) begin
            miscompares++;
            $display("FAIL random_stream: got %0d stream beats vs %0d W beats expected equal", t_n, w_n);
        end
    endtask

    task automatic test_reset_mid();
        int w0, t;
        bit reached;
        w0 = w_n;
        do_start(64'h0, 32'd8256, t);
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (w_n - w0 >= 74) begin
                reached = 1'b1;
                break;
            end
        end
        vectors++;
        if (!reached || bus.m_axi_wvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_setup: got reached %0d wvalid %b expected 1/1", reached, bus.m_axi_wvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast, bus.s_axis_tready,
             bus.ctrl_done, bus.m_axi_bready} !== 6'b0 || bus.m_axi_awaddr !== '0 || bus.m_axi_awlen !== 8'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got %b addr %h len %0d expected 000000/0/0",
                     {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast, bus.s_axis_tready,
                      bus.ctrl_done, bus.m_axi_bready}, bus.m_axi_awaddr, bus.m_axi_awlen);
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_after_reset();
        test_transfer("post_reset", 64'h2000, 32'd4096, 64, 1);
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_three_bursts();
        test_zero_size();
        test_outstanding();
        test_random_flow();
        test_reset_mid();
        test_after_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
